// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and width helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; a 1- or 2-bit operand still needs a 1-bit counter.
  function automatic int cntWidth(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between upstream, the sequencer and downstream.
interface serial_add_ctrl_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// The single combinational 1-bit full-adder cell shared by every bit position.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: operands stream LSB first through one full-adder
// cell and a carry flip-flop, one bit per clock, with valid/ready on both sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = cntWidth(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state_q;
  logic [W-1:0]     a_sh_q;
  logic [W-1:0]     b_sh_q;
  logic [W-1:0]     sum_sh_q;
  logic [W-1:0]     sum_sh_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             s_bit;
  logic             co_bit;

  fa_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (s_bit),
    .co_o (co_bit)
  );

  // Result bits enter at the MSB so after W shifts bit 0 sits at the LSB.
  generate
    if (W == 1) begin : g_sum_w1
      assign sum_sh_d = s_bit;
    end else begin : g_sum_wn
      assign sum_sh_d = {s_bit, sum_sh_q[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q     <= bus.op_a;
            b_sh_q     <= bus.op_b;
            carry_q    <= bus.cin;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= co_bit;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus a random sweep
// on a W=8 instance and exhaustive coverage on a W=1 instance.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_add_ctrl_if #(.W(8)) b8 ();
  serial_add_ctrl_if #(.W(1)) b1 ();

  serial_add_ctrl #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  serial_add_ctrl #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // One W=8 operation: optional stall in DONE and an optional in_valid pulse during RUN.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input int stall, input bit pulse);
    logic [8:0] expSum;
    int         cycles;
    expSum = {1'b0, a} + {1'b0, b} + {8'b0, c};
    checkOutput("idle_in_ready", b8.in_ready, 1);
    b8.in_valid  = 1'b1;
    b8.op_a      = a;
    b8.op_b      = b;
    b8.cin       = c;
    b8.out_ready = (stall == 0);
    stepEdge();
    b8.in_valid = 1'b0;
    checkOutput("run_busy", b8.busy, 1);
    checkOutput("run_in_ready", b8.in_ready, 0);
    cycles = 0;
    while (!b8.out_valid && cycles < 40) begin
      if (pulse && cycles == 3) begin
        b8.in_valid = 1'b1;
        b8.op_a     = ~a;
        b8.op_b     = b ^ 8'h5A;
        b8.cin      = ~c;
      end else begin
        b8.in_valid = 1'b0;
      end
      stepEdge();
      cycles++;
      if (pulse && cycles == 4) checkOutput("pulse_in_ready", b8.in_ready, 0);
    end
    b8.in_valid = 1'b0;
    checkOutput("latency", cycles, 8);
    checkOutput("sum", b8.sum, expSum[7:0]);
    checkOutput("cout", b8.cout, expSum[8]);
    checkOutput("done_busy", b8.busy, 1);
    for (int i = 0; i < stall; i++) begin
      stepEdge();
      checkOutput("hold_valid", b8.out_valid, 1);
      checkOutput("hold_sum", b8.sum, expSum[7:0]);
      checkOutput("hold_cout", b8.cout, expSum[8]);
    end
    b8.out_ready = 1'b1;
    stepEdge();
    checkOutput("ret_out_valid", b8.out_valid, 0);
    checkOutput("ret_in_ready", b8.in_ready, 1);
    checkOutput("ret_busy", b8.busy, 0);
  endtask

  task automatic applyStimulus1(input logic a, input logic b, input logic c);
    logic [1:0] expSum;
    expSum = {1'b0, a} + {1'b0, b} + {1'b0, c};
    b1.in_valid  = 1'b1;
    b1.op_a      = a;
    b1.op_b      = b;
    b1.cin       = c;
    b1.out_ready = 1'b0;
    stepEdge();
    b1.in_valid = 1'b0;
    checkOutput("w1_not_valid_yet", b1.out_valid, 0);
    stepEdge();
    checkOutput("w1_out_valid", b1.out_valid, 1);
    checkOutput("w1_result", {b1.cout, b1.sum}, expSum);
    b1.out_ready = 1'b1;
    stepEdge();
    checkOutput("w1_idle", b1.in_ready, 1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    b8.in_valid  = 1'b0;
    b8.op_a      = '0;
    b8.op_b      = '0;
    b8.cin       = 1'b0;
    b8.out_ready = 1'b0;
    b1.in_valid  = 1'b0;
    b1.op_a      = '0;
    b1.op_b      = '0;
    b1.cin       = 1'b0;
    b1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", b8.in_ready, 1);
    checkOutput("rst_out_valid", b8.out_valid, 0);
    checkOutput("rst_busy", b8.busy, 0);
    checkOutput("rst_sum", b8.sum, 0);
    checkOutput("rst_cout", b8.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stepEdge();

    applyStimulus(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    applyStimulus(8'h3C, 8'h41, 1'b1, 0, 1'b0);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 5, 1'b0);
    applyStimulus(8'h27, 8'h19, 1'b0, 0, 1'b1);

    // Abort mid-RUN: outputs must drop to reset values without a clock edge.
    b8.in_valid = 1'b1;
    b8.op_a     = 8'h12;
    b8.op_b     = 8'h34;
    b8.cin      = 1'b1;
    stepEdge();
    b8.in_valid = 1'b0;
    repeat (4) stepEdge();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", b8.in_ready, 1);
    checkOutput("abort_out_valid", b8.out_valid, 0);
    checkOutput("abort_busy", b8.busy, 0);
    checkOutput("abort_sum", b8.sum, 0);
    checkOutput("abort_cout", b8.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stepEdge();
    applyStimulus(8'h80, 8'h80, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 8; k++) begin
      applyStimulus1(k[2], k[1], k[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
